// File: rtl/alu_pkg.sv
// Shared EX-stage adder constants: datapath width and result-owner IDs.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 64;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_AGU = 1'b1;

endpackage

// File: rtl/FA_64bit_sync.sv
// Combinational ripple-carry adder: {carry_o, sum_o} = a_i + b_i + cin_i.
module FA_64bit_sync #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    carry_o = c[WIDTH];
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin pick; the remembered last winner only advances when update_en_i is set.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o,
  output logic       gnt_any_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_any_o = |req_i;
    // On contention the side that did not win last time goes next.
    gnt_id_o  = (&req_i) ? ~last_q : req_i[1];
    gnt_o     = '0;
    if (gnt_any_o) begin
      gnt_o[gnt_id_o] = 1'b1;
    end
    last_d = update_en_i ? gnt_id_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple adder between the ALU and AGU requesters; result held in a single
// valid/ready output register.
module adder_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_carry
);

  logic [1:0]       gnt;
  logic             gnt_id, gnt_any;
  logic             can_accept, accept;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_carry;

  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_carry_q, resp_carry_d;

  rr_arb2 u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       ({req1_valid, req0_valid}),
    .update_en_i (accept),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_any_o   (gnt_any)
  );

  FA_64bit_sync #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i     (add_a),
    .b_i     (add_b),
    .cin_i   (add_cin),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    can_accept = !resp_valid_q || resp_ready;
    req0_ready = gnt[0] && can_accept && !rst;
    req1_ready = gnt[1] && can_accept && !rst;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (gnt_any) begin
      if (gnt_id == REQ_AGU) begin
        add_a   = req1_a;
        add_b   = req1_b;
        add_cin = req1_cin;
      end else begin
        add_a   = req0_a;
        add_b   = req0_b;
        add_cin = req0_cin;
      end
    end

    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_id;
      resp_sum_d   = add_sum;
      resp_carry_d = add_carry;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= REQ_ALU;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_carry = resp_carry_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed bench for adder_share_arbiter against a behavioural model.
module tb_adder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_cin, req0_ready;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_cin, req1_ready;
  logic [63:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_carry;
  logic [63:0] resp_sum;

  int checks = 0;
  int errors = 0;

  // Model state: last winner and the result register contents.
  logic        m_last, m_v, m_id, m_c;
  logic [63:0] m_sum;
  logic        m_e0, m_e1;
  logic        tb_live = 1'b0;

  // Outputs sampled by the most recent cycle call.
  logic        s_r0, s_r1, s_valid, s_id, s_carry;
  logic [63:0] s_sum;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, compare against the model, then advance the model past the edge.
  task automatic cycle(input logic r, input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                       input logic c0, input logic v1, input logic [63:0] a1,
                       input logic [63:0] b1, input logic c1, input logic rr);
    logic        can, w, hasw;
    logic [64:0] full;
    rst = r; resp_ready = rr;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #3;
    can  = !m_v || rr;
    hasw = v0 || v1;
    w    = (v0 && v1) ? ~m_last : v1;
    m_e0 = !r && can && hasw && !w;
    m_e1 = !r && can && hasw && w;
    chk("req0_ready", req0_ready, m_e0);
    chk("req1_ready", req1_ready, m_e1);
    chk("resp_valid", resp_valid, m_v);
    chk("resp_id", resp_id, m_id);
    chk("resp_sum", resp_sum, m_sum);
    chk("resp_carry", resp_carry, m_c);
    s_r0 = req0_ready; s_r1 = req1_ready; s_valid = resp_valid;
    s_id = resp_id; s_sum = resp_sum; s_carry = resp_carry;
    if (r) begin
      m_v = 1'b0; m_id = 1'b0; m_sum = '0; m_c = 1'b0; m_last = 1'b1;
    end else if (m_e0 || m_e1) begin
      full   = w ? ({1'b0, a1} + {1'b0, b1} + 65'(c1)) : ({1'b0, a0} + {1'b0, b0} + 65'(c0));
      m_sum  = full[63:0];
      m_c    = full[64];
      m_v    = 1'b1;
      m_id   = w;
      m_last = w;
    end else if (rr) begin
      m_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rr);
  endtask

  // Protocol watch: one-hot readies, and held result stable under backpressure.
  logic        p_v, p_rr, p_rst, p_id, p_c;
  logic [63:0] p_sum;
  always @(negedge clk) begin
    if (tb_live) begin
      checks++;
      assert (!(req0_ready && req1_ready)) else begin
        errors++;
        $display("FAIL ready_onehot: got %b%b required at most one", req0_ready, req1_ready);
      end
      if (p_v && !p_rr && !p_rst) begin
        checks++;
        assert (resp_valid && resp_id == p_id && resp_sum == p_sum && resp_carry == p_c) else begin
          errors++;
          $display("FAIL resp_stable: got %b %b %h %b required 1 %b %h %b",
                   resp_valid, resp_id, resp_sum, resp_carry, p_id, p_sum, p_c);
        end
      end
    end
    p_v = resp_valid; p_rr = resp_ready; p_rst = rst;
    p_id = resp_id; p_sum = resp_sum; p_c = resp_carry;
  end

  initial begin
    logic        g0 [4];
    logic        ids [4];
    logic        h0, h1, v0, v1, c0, c1;
    logic [63:0] a0, b0, a1, b1;
    logic [63:0] ones;
    ones = '1;
    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    @(posedge clk);
    #1;
    m_last = 1'b1; m_v = 1'b0; m_id = 1'b0; m_sum = '0; m_c = 1'b0;
    tb_live = 1'b1;

    cycle(1'b1, 1'b1, 64'd1, 64'd2, 1'b0, 1'b1, 64'd3, 64'd4, 1'b0, 1'b1);
    chk("rst_no_ready", {s_r0, s_r1}, 2'b00);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("reset_valid", s_valid, 1'b0);
    chk("reset_sum", s_sum, 64'h0);
    chk("idle_no_ready", {s_r0, s_r1}, 2'b00);

    // Single request.
    cycle(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h8765_4321_0FED_CBA9, 1'b0,
          1'b0, '0, '0, 1'b0, 1'b1);
    chk("single_ready", s_r0, 1'b1);
    idle(1'b1);
    chk("single_valid", s_valid, 1'b1);
    chk("single_id", s_id, 1'b0);
    chk("single_sum", s_sum, 64'h9999_9999_AAAA_AA99);
    chk("single_carry", s_carry, 1'b0);

    // Carry-out from requester 1.
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 64'h1111_1111_1111_1111, ones, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ones, ones, 1'b1, 1'b1);
    chk("carry_id", s_id, 1'b1);
    chk("carry_sum", s_sum, 64'h1111_1111_1111_1110);
    chk("carry_carry", s_carry, 1'b1);
    idle(1'b1);
    chk("allones_sum", s_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("allones_carry", s_carry, 1'b1);

    // Contention right after reset.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 64'd10, 64'd20, 1'b0, 1'b1, 64'd100, 64'd200, 1'b1, 1'b1);
      g0[i] = s_r0;
      if (i > 0) ids[i-1] = s_id;
    end
    idle(1'b1);
    ids[3] = s_id;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend_grant0_%0d", i), g0[i], (i % 2 == 0));
      chk($sformatf("contend_id_%0d", i), ids[i], (i % 2 == 1));
    end

    // Backpressure: requester 0 accepted, then consumer stalls 3 cycles.
    cycle(1'b0, 1'b1, 64'd5, 64'd7, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 64'd9, 64'd9, 1'b0, 1'b0);
      chk("bp_no_ready", {s_r0, s_r1}, 2'b00);
      chk("bp_sum", s_sum, 64'hC);
      chk("bp_valid", s_valid, 1'b1);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 64'd9, 64'd9, 1'b0, 1'b1);
    chk("bp_release_grant", s_r1, 1'b1);
    idle(1'b1);

    // Reset in the cycle after an accept.
    cycle(1'b0, 1'b1, 64'd1, 64'd1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 64'd2, 64'd2, 1'b0, 1'b1, 64'd3, 64'd3, 1'b0, 1'b1);
    chk("midrst_no_ready", {s_r0, s_r1}, 2'b00);
    cycle(1'b0, 1'b1, 64'd2, 64'd2, 1'b0, 1'b1, 64'd3, 64'd3, 1'b0, 1'b1);
    chk("midrst_valid", s_valid, 1'b0);
    chk("midrst_first_grant", s_r0, 1'b1);
    idle(1'b1);

    // Random traffic with requester hold-until-ready discipline.
    h0 = 1'b0; h1 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = 1'b0; c1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!h0) begin
        v0 = ($urandom_range(0, 2) != 0);
        a0 = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom};
        b0 = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom};
        c0 = 1'($urandom_range(0, 1));
      end
      if (!h1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom};
        b1 = ($urandom_range(0, 7) == 0) ? ones : {$urandom, $urandom};
        c1 = 1'($urandom_range(0, 1));
      end
      cycle(($urandom_range(0, 99) < 2), v0, a0, b0, c0, v1, a1, b1, c1,
            ($urandom_range(0, 9) < 7));
      h0 = v0 && !m_e0;
      h1 = v1 && !m_e1;
    end

    tb_live = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
